// File: rtl/uart_rx_ctrl_sched.sv
// Control wrapper around the UART RX core: shadowed configuration applied only
// while RX is idle, an output byte FIFO with valid/ready, and a saturating error counter.
module uart_rx_ctrl_sched #(
  parameter int DATA_WIDTH    = 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          syn_reset,
  input  logic                          cfg_wr_en,
  input  logic                          cfg_parity_enable,
  input  logic                          cfg_parity_type,
  input  logic [5:0]                    cfg_prescale,
  output logic                          cfg_busy,
  output logic [1:0]                    cfg_state,
  input  logic                          rx_busy,
  output logic                          rx_enable,
  output logic                          rx_parity_enable,
  output logic                          rx_parity_type,
  output logic [5:0]                    rx_prescale,
  input  logic                          rx_data_valid,
  input  logic [DATA_WIDTH-1:0]         rx_p_data,
  input  logic                          rx_parity_error,
  input  logic                          rx_stop_error,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun_err,
  output logic [ERR_CNT_WIDTH-1:0]      err_count,
  input  logic                          err_clr
);

  // Handshake: a byte leaves the FIFO on a rising edge where out_valid && out_ready;
  // out_data is stable while out_valid is high and out_ready is low.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = ERR_CNT_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_APPLY = 2'd2
  } cfg_state_t;

  cfg_state_t state;
  logic       pend_parity_enable;
  logic       pend_parity_type;
  logic [5:0] pend_prescale;

  assign cfg_state = state;

  function automatic logic prescale_ok(input logic [5:0] p);
    return (p == 6'd8) || (p == 6'd16) || (p == 6'd32);
  endfunction

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      state              <= ST_RUN;
      cfg_busy           <= 1'b0;
      rx_enable          <= 1'b1;
      rx_parity_enable   <= 1'b0;
      rx_parity_type     <= 1'b0;
      rx_prescale        <= 6'd8;
      pend_parity_enable <= 1'b0;
      pend_parity_type   <= 1'b0;
      pend_prescale      <= 6'd8;
    end else begin
      case (state)
        ST_RUN: begin
          if (cfg_wr_en) begin
            pend_parity_enable <= cfg_parity_enable;
            pend_parity_type   <= cfg_parity_type;
            pend_prescale      <= cfg_prescale;
            cfg_busy           <= 1'b1;
            rx_enable          <= 1'b0;
            state              <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Wait for any in-flight frame to finish before touching RX settings.
          if (!rx_busy) state <= ST_APPLY;
        end
        ST_APPLY: begin
          rx_parity_enable <= pend_parity_enable;
          rx_parity_type   <= pend_parity_type;
          if (prescale_ok(pend_prescale)) rx_prescale <= pend_prescale;
          cfg_busy  <= 1'b0;
          rx_enable <= 1'b1;
          state     <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  do_pop;
  logic                  do_push;
  logic                  overrun_evt;

  assign full        = (count == CW'(FIFO_DEPTH));
  assign out_valid   = (count != '0);
  assign out_data    = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count  = count;
  assign do_pop      = out_valid && out_ready;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign do_push     = rx_data_valid && (!full || do_pop);
  assign overrun_evt = rx_data_valid && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= rx_p_data;
  end

  always_ff @(posedge clk) begin
    if (syn_reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= overrun_evt;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  logic [SW-1:0] err_sum;

  assign err_sum = {2'b00, err_count}
                 + {{(SW-1){1'b0}}, rx_parity_error}
                 + {{(SW-1){1'b0}}, rx_stop_error}
                 + {{(SW-1){1'b0}}, overrun_evt};

  always_ff @(posedge clk) begin
    if (syn_reset || err_clr) begin
      err_count <= '0;
    end else if (err_sum > {2'b00, {ERR_CNT_WIDTH{1'b1}}}) begin
      err_count <= '1;
    end else begin
      err_count <= err_sum[ERR_CNT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl_sched.sv
// Bench for uart_rx_ctrl_sched: directed stimulus, byte scoreboard checked by a
// negedge monitor, plus direct checks of config, FIFO status and error counter.
module tb_uart_rx_ctrl_sched;

  logic       clk = 1'b0;
  logic       syn_reset;
  logic       cfg_wr_en;
  logic       cfg_parity_enable;
  logic       cfg_parity_type;
  logic [5:0] cfg_prescale;
  logic       cfg_busy;
  logic [1:0] cfg_state;
  logic       rx_busy;
  logic       rx_enable;
  logic       rx_parity_enable;
  logic       rx_parity_type;
  logic [5:0] rx_prescale;
  logic       rx_data_valid;
  logic [7:0] rx_p_data;
  logic       rx_parity_error;
  logic       rx_stop_error;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] fifo_count;
  logic       overrun_err;
  logic [7:0] err_count;
  logic       err_clr;

  int tests  = 0;
  int failed = 0;
  logic [7:0] exp_q[$];

  uart_rx_ctrl_sched #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .syn_reset(syn_reset),
    .cfg_wr_en(cfg_wr_en), .cfg_parity_enable(cfg_parity_enable),
    .cfg_parity_type(cfg_parity_type), .cfg_prescale(cfg_prescale),
    .cfg_busy(cfg_busy), .cfg_state(cfg_state),
    .rx_busy(rx_busy), .rx_enable(rx_enable),
    .rx_parity_enable(rx_parity_enable), .rx_parity_type(rx_parity_type),
    .rx_prescale(rx_prescale),
    .rx_data_valid(rx_data_valid), .rx_p_data(rx_p_data),
    .rx_parity_error(rx_parity_error), .rx_stop_error(rx_stop_error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .overrun_err(overrun_err),
    .err_count(err_count), .err_clr(err_clr)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted output byte must match the queue head.
  always @(negedge clk) begin
    if (!syn_reset && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL out_data_unexpected: got %0h, queue empty", out_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failed++;
          $display("FAIL out_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] d, input bit expect_out);
    rx_data_valid = 1'b1;
    rx_p_data     = d;
    if (expect_out) exp_q.push_back(d);
    cyc();
    rx_data_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic pe, input logic pt, input logic [5:0] ps);
    cfg_wr_en         = 1'b1;
    cfg_parity_enable = pe;
    cfg_parity_type   = pt;
    cfg_prescale      = ps;
    cyc();
    cfg_wr_en = 1'b0;
  endtask

  initial begin
    syn_reset = 1'b1; cfg_wr_en = 1'b0; cfg_parity_enable = 1'b0; cfg_parity_type = 1'b0;
    cfg_prescale = 6'd8; rx_busy = 1'b0; rx_data_valid = 1'b0; rx_p_data = 8'h00;
    rx_parity_error = 1'b0; rx_stop_error = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    cyc(); cyc();
    at_neg();
    chk("rst_rx_enable", rx_enable, 1);
    chk("rst_cfg_busy", cfg_busy, 0);
    chk("rst_state", cfg_state, 0);
    chk("rst_prescale", rx_prescale, 8);
    chk("rst_parity", {rx_parity_enable, rx_parity_type}, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_overrun", overrun_err, 0);
    chk("rst_err_count", err_count, 0);
    syn_reset = 1'b0;
    cyc();

    // 1: three bytes, then drain in order
    push_byte(8'hA5, 1); push_byte(8'h3C, 1); push_byte(8'hFF, 1);
    at_neg();
    chk("t1_count", fifo_count, 3);
    chk("t1_head", out_data, 8'hA5);
    cyc();
    out_ready = 1'b1;
    cyc(); cyc(); cyc();
    at_neg();
    chk("t1_empty", out_valid, 0);
    cyc();
    out_ready = 1'b0;

    // 2: overrun when full, then push+pop at full
    push_byte(8'h01, 1); push_byte(8'h02, 1); push_byte(8'h03, 1); push_byte(8'h04, 1);
    at_neg();
    chk("t2_full", fifo_count, 4);
    cyc();
    push_byte(8'h11, 0);
    at_neg();
    chk("t2_overrun", overrun_err, 1);
    chk("t2_err_count", err_count, 1);
    chk("t2_head", out_data, 8'h01);
    chk("t2_count_kept", fifo_count, 4);
    cyc();
    at_neg();
    chk("t2_overrun_pulse", overrun_err, 0);
    cyc();
    out_ready = 1'b1;
    push_byte(8'h22, 1);
    out_ready = 1'b0;
    at_neg();
    chk("t2_no_overrun", overrun_err, 0);
    chk("t2_count4", fifo_count, 4);
    chk("t2_err_same", err_count, 1);
    chk("t2_new_head", out_data, 8'h02);
    cyc();
    out_ready = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    out_ready = 1'b0;
    at_neg();
    chk("t2_drained", out_valid, 0);
    cyc();

    // 3/4: config held while RX busy, second request ignored
    rx_busy = 1'b1;
    cfg_write(1'b1, 1'b1, 6'd16);
    at_neg();
    chk("t3_busy", cfg_busy, 1);
    chk("t3_rx_enable", rx_enable, 0);
    chk("t3_state_hold", cfg_state, 1);
    chk("t3_prescale_held", rx_prescale, 8);
    chk("t3_parity_held", {rx_parity_enable, rx_parity_type}, 0);
    cyc();
    cfg_write(1'b0, 1'b0, 6'd32);
    cyc(); cyc();
    at_neg();
    chk("t4_still_hold", cfg_state, 1);
    chk("t4_prescale_held", rx_prescale, 8);
    push_byte(8'h5A, 1);
    rx_busy = 1'b0;
    cyc();
    at_neg();
    chk("t3_apply", cfg_state, 2);
    chk("t3_busy_apply", cfg_busy, 1);
    cyc();
    at_neg();
    chk("t3_prescale16", rx_prescale, 16);
    chk("t3_parity11", {rx_parity_enable, rx_parity_type}, 2'b11);
    chk("t3_rx_enable1", rx_enable, 1);
    chk("t3_busy0", cfg_busy, 0);
    chk("t3_run", cfg_state, 0);
    chk("t3_byte_kept", fifo_count, 1);
    cyc();
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;

    // invalid prescale: parity applied, prescale kept
    cfg_write(1'b0, 1'b1, 6'd20);
    cyc(); cyc();
    at_neg();
    chk("t4_bad_prescale", rx_prescale, 16);
    chk("t4_bad_parity", {rx_parity_enable, rx_parity_type}, 2'b01);
    chk("t4_bad_busy", cfg_busy, 0);
    cyc();

    // 5: error counter
    err_clr = 1'b1; cyc(); err_clr = 1'b0;
    at_neg();
    chk("t5_clr", err_count, 0);
    cyc();
    rx_parity_error = 1'b1; rx_stop_error = 1'b1;
    cyc();
    rx_parity_error = 1'b0; rx_stop_error = 1'b0;
    at_neg();
    chk("t5_plus2", err_count, 2);
    cyc();
    rx_parity_error = 1'b1; rx_stop_error = 1'b1;
    for (int i = 0; i < 130; i++) cyc();
    rx_stop_error = 1'b0;
    at_neg();
    chk("t5_sat", err_count, 255);
    cyc();
    at_neg();
    chk("t5_sat_hold", err_count, 255);
    cyc();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0; rx_parity_error = 1'b0;
    at_neg();
    chk("t5_clr_wins", err_count, 0);
    cyc();

    // 6: reset during HOLD with bytes queued
    push_byte(8'h77, 0); push_byte(8'h88, 0);
    rx_busy = 1'b1;
    cfg_write(1'b1, 1'b0, 6'd32);
    at_neg();
    chk("t6_hold", cfg_busy, 1);
    chk("t6_count2", fifo_count, 2);
    cyc();
    syn_reset = 1'b1;
    cyc();
    syn_reset = 1'b0;
    rx_busy = 1'b0;
    at_neg();
    chk("t6_count0", fifo_count, 0);
    chk("t6_busy0", cfg_busy, 0);
    chk("t6_prescale8", rx_prescale, 8);
    chk("t6_rx_enable", rx_enable, 1);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_parity", {rx_parity_enable, rx_parity_type}, 0);
    cyc(); cyc();

    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
